// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/LSU requesters, the arbiter and the
// single-port data memory. The arbiter connects through the slave modport;
// the environment (requesters + memory model) uses the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency 64-bit memory port between instruction
// fetch (IF) and load/store (LS). One transaction at a time; LS has fixed
// priority with a starvation guard that forces an IF grant after STARVE_MAX
// consecutive LS grants taken while IF was waiting.
// Build option: define ARB_RR_EN to replace fixed priority with round-robin
// between the two requesters when both are present.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4    // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,   // synchronous, active-low
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Arbitration decision for the current IDLE cycle
    logic grant;
    logic if_wins;

`ifdef ARB_RR_EN
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_e;

    req_e rr_last_q, rr_last_d;
`else
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    // Registered outputs
    logic              if_gnt_q,    if_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              ls_gnt_q,    ls_gnt_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Pick a winner: sole requester wins; on contention LS wins unless IF is
    // starved (or, in round-robin builds, whoever was not granted last wins)
    always_comb begin
        grant = (state_q == IDLE) && (bus.if_req || bus.ls_req);
`ifdef ARB_RR_EN
        if_wins = (bus.if_req && bus.ls_req) ? (rr_last_q == REQ_LS) : bus.if_req;
`else
        if_wins = (bus.if_req && bus.ls_req) ? (starve_cnt_q == STARVE_LIMIT) : bus.if_req;
`endif
    end

    // State register plus all output and bookkeeping flops
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order inside this block.
        if (!reset) begin
            // NOTE: data registers are cleared too, so rdata/mem buses read 0
            // after reset rather than stale contents of an abandoned access.
            state_q      <= IDLE;
`ifdef ARB_RR_EN
            rr_last_q    <= REQ_IF;
`else
            starve_cnt_q <= '0;
`endif
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_gnt_q     <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            ls_rdata_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
`ifdef ARB_RR_EN
            rr_last_q    <= rr_last_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
            if_gnt_q     <= if_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_gnt_q     <= ls_gnt_d;
            ls_rvalid_q  <= ls_rvalid_d;
            ls_rdata_q   <= ls_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next state: grant from IDLE, return to IDLE when the memory completes
    always_comb begin
        // NOTE: assign a default before any branch; a path that leaves a
        // combinational variable unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:           if (grant) state_d = if_wins ? IF_ACC : LS_ACC;
            IF_ACC, LS_ACC: if (bus.mem_ready) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Fairness history: starvation counter or last-granted requester
    always_comb begin
`ifdef ARB_RR_EN
        rr_last_d = rr_last_q;
        if (grant) rr_last_d = if_wins ? REQ_IF : REQ_LS;
`else
        starve_cnt_d = starve_cnt_q;
        if (grant) begin
            if (if_wins || !bus.if_req)
                starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_LIMIT)
                starve_cnt_d = starve_cnt_q + 4'd1;
        end
`endif
    end

    // Outputs: launch the winner onto the memory bus, then capture the reply
    always_comb begin
        if_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_gnt_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    mem_req_d = 1'b1;
                    if (if_wins) begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end else begin
                        ls_gnt_d    = 1'b1;
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                    end
                end
            end
            IF_ACC: begin
                if (bus.mem_ready) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = bus.mem_rdata;
                end
            end
            LS_ACC: begin
                if (bus.mem_ready) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    ls_rvalid_d = 1'b1;
                    // mem_we_q still holds the captured store flag here
                    if (!mem_we_q) ls_rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single IF read, delayed store,
// contention ordering, late LS request, reset mid-access, idle mem_ready.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic busy;
    int   n_pass;
    int   n_total;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_total++;
        if ({busy, bus.mem_req, bus.mem_we, bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000000", {busy, bus.mem_req, bus.mem_we, bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid});
        end else n_pass++;
        n_total++;
        if ({bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata} !== 256'h0) begin
            $display("FAIL reset_data: got %h %h %h %h want all 0", bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata);
        end else n_pass++;
    endtask

    task automatic test_idle_ready();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if ({busy, bus.mem_req, bus.if_rvalid, bus.ls_rvalid, bus.if_gnt, bus.ls_gnt} !== 6'b0 ||
                bus.mem_addr !== 64'h0 || bus.if_rdata !== 64'h0 || bus.ls_rdata !== 64'h0) begin
                $display("FAIL idle_ready: busy=%b mem_req=%b rv=%b%b addr=%h want all 0",
                         busy, bus.mem_req, bus.if_rvalid, bus.ls_rvalid, bus.mem_addr);
            end else n_pass++;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_if_read();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h10;
        tick();
        n_total++;
        if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, busy} !== 5'b10101 || bus.mem_addr !== 64'h10) begin
            $display("FAIL if_grant: gnt=%b%b req=%b we=%b busy=%b addr=%h want 10 1 0 1 10",
                     bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.mem_we, busy, bus.mem_addr);
        end else n_pass++;
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h00A00093;
        tick();
        n_total++;
        if ({bus.if_rvalid, bus.if_gnt, bus.mem_req, busy} !== 4'b1000 || bus.if_rdata !== 64'h00A00093) begin
            $display("FAIL if_rvalid: rv=%b gnt=%b req=%b busy=%b rdata=%h want 1 0 0 0 00a00093",
                     bus.if_rvalid, bus.if_gnt, bus.mem_req, busy, bus.if_rdata);
        end else n_pass++;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'h0;
        tick();
        n_total++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 64'h00A00093 || busy !== 1'b0) begin
            $display("FAIL if_after: rv=%b rdata=%h busy=%b want 0 00a00093 0", bus.if_rvalid, bus.if_rdata, busy);
        end else n_pass++;
    endtask

    task automatic test_ls_store();
        int rv_count = 0;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 64'h100;
        bus.ls_wdata = 64'hDEADBEEF;
        tick();
        n_total++;
        if ({bus.ls_gnt, bus.if_gnt, bus.mem_req, bus.mem_we} !== 4'b1011 ||
            bus.mem_addr !== 64'h100 || bus.mem_wdata !== 64'hDEADBEEF) begin
            $display("FAIL st_grant: gnt=%b req=%b we=%b addr=%h wdata=%h want 1 1 1 100 deadbeef",
                     bus.ls_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end else n_pass++;
        // Requester moves on; the memory bus must keep the captured values
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_wdata = 64'h0BAD;
        bus.ls_addr  = 64'h999;
        for (int c = 2; c <= 3; c++) begin
            tick();
            n_total++;
            if ({bus.mem_req, bus.mem_we, bus.ls_gnt, bus.ls_rvalid, busy} !== 5'b11001 ||
                bus.mem_addr !== 64'h100 || bus.mem_wdata !== 64'hDEADBEEF) begin
                $display("FAIL st_hold_c%0d: req=%b we=%b gnt=%b rv=%b addr=%h wdata=%h want 1 1 0 0 100 deadbeef",
                         c, bus.mem_req, bus.mem_we, bus.ls_gnt, bus.ls_rvalid, bus.mem_addr, bus.mem_wdata);
            end else n_pass++;
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1234;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.ls_rvalid === 1'b1) rv_count++;
            if (c == 0) begin
                bus.mem_ready = 1'b0;
                n_total++;
                if ({bus.mem_req, bus.mem_we, busy} !== 3'b000 || bus.ls_rdata !== 64'h0) begin
                    $display("FAIL st_done: req=%b we=%b busy=%b ls_rdata=%h want 0 0 0 0",
                             bus.mem_req, bus.mem_we, busy, bus.ls_rdata);
                end else n_pass++;
            end
        end
        n_total++;
        if (rv_count != 1) begin
            $display("FAIL st_rvalid_pulses: got %0d want 1", rv_count);
        end else n_pass++;
    endtask

    task automatic test_late_ls();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h20;
        tick();
        bus.if_req   = 1'b0;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = 64'h200;
        bus.ls_wdata = 64'h0;
        tick();
        n_total++;
        if (bus.ls_gnt !== 1'b0 || busy !== 1'b1 || bus.mem_addr !== 64'h20) begin
            $display("FAIL late_ignored: ls_gnt=%b busy=%b addr=%h want 0 1 20", bus.ls_gnt, busy, bus.mem_addr);
        end else n_pass++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h55;
        tick();
        bus.mem_ready = 1'b0;
        n_total++;
        if (bus.if_rvalid !== 1'b1 || bus.ls_gnt !== 1'b0 || bus.if_rdata !== 64'h55) begin
            $display("FAIL late_if_done: if_rv=%b ls_gnt=%b if_rdata=%h want 1 0 55", bus.if_rvalid, bus.ls_gnt, bus.if_rdata);
        end else n_pass++;
        tick();
        n_total++;
        if (bus.ls_gnt !== 1'b1 || bus.mem_addr !== 64'h200 || bus.mem_we !== 1'b0) begin
            $display("FAIL late_ls_grant: ls_gnt=%b addr=%h we=%b want 1 200 0", bus.ls_gnt, bus.mem_addr, bus.mem_we);
        end else n_pass++;
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hCAFE;
        tick();
        bus.mem_ready = 1'b0;
        n_total++;
        if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 64'hCAFE) begin
            $display("FAIL late_ls_load: rv=%b rdata=%h want 1 cafe", bus.ls_rvalid, bus.ls_rdata);
        end else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 64'h300;
        tick();
        bus.ls_req = 1'b0;
        tick();
        // Second ACC cycle, memory still not ready
        reset = 1'b0;
        tick();
        n_total++;
        if ({bus.mem_req, busy, bus.ls_rvalid, bus.if_rvalid} !== 4'b0 ||
            bus.if_rdata !== 64'h0 || bus.ls_rdata !== 64'h0 || bus.mem_addr !== 64'h0) begin
            $display("FAIL rst_mid: req=%b busy=%b rv=%b%b if_rdata=%h ls_rdata=%h addr=%h want all 0",
                     bus.mem_req, busy, bus.ls_rvalid, bus.if_rvalid, bus.if_rdata, bus.ls_rdata, bus.mem_addr);
        end else n_pass++;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        n_total++;
        if (bus.ls_rvalid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_abandon: ls_rv=%b busy=%b want 0 0", bus.ls_rvalid, busy);
        end else n_pass++;
        bus.mem_ready = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 64'h18;
        tick();
        n_total++;
        if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 64'h18) begin
            $display("FAIL rst_if_grant: gnt=%b addr=%h want 1 18", bus.if_gnt, bus.mem_addr);
        end else n_pass++;
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h77;
        tick();
        bus.mem_ready = 1'b0;
        n_total++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 64'h77) begin
            $display("FAIL rst_if_done: rv=%b rdata=%h want 1 77", bus.if_rvalid, bus.if_rdata);
        end else n_pass++;
        tick();
    endtask

    task automatic test_priority();
        bit exp_if [10];
        int got = 0;
        logic [63:0] exp_addr;
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_RR_EN
            exp_if[i] = (i % 2 == 1);
`else
            exp_if[i] = (i % 5 == 4);
`endif
        end
        // Fresh reset so the fairness history starts from its reset value
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 64'h40;
        bus.ls_req    = 1'b1;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = 64'h80;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hABC;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            tick();
            if (bus.if_gnt === 1'b1 || bus.ls_gnt === 1'b1) begin
                exp_addr = exp_if[got] ? 64'h40 : 64'h80;
                n_total++;
                if (bus.if_gnt !== exp_if[got] || bus.ls_gnt !== !exp_if[got] || bus.mem_addr !== exp_addr) begin
                    $display("FAIL prio_grant%0d: if_gnt=%b ls_gnt=%b addr=%h want %b %b %h",
                             got, bus.if_gnt, bus.ls_gnt, bus.mem_addr, exp_if[got], !exp_if[got], exp_addr);
                end else n_pass++;
                got++;
            end
        end
        n_total++;
        if (got != 10) begin
            $display("FAIL prio_count: got %0d grants want 10", got);
        end else n_pass++;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        tick();
        tick();
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        test_idle_ready();
        test_if_read();
        test_ls_store();
        test_late_ls();
        test_reset_mid();
        test_priority();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
